teknofest_prog_loader: RTL

TEKNOFEST_PROG_LOADER -- requirements
Module: teknofest_prog_loader

---
 rtl/teknofest_prog_loader.sv | 352 +++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/teknofest_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : teknofest_prog_loader
// Description : UART program loader. Waits for the ASCII key "TEKNOFEST",
//               reads a little-endian 32-bit byte count, then packs the
//               payload into BLOCK_SIZE-bit RAM lines and writes them out.
//               Holds the CPU in reset while a transfer is in progress.
// Revision    : 1.0 - initial release
// ============================================================================
module teknofest_prog_loader #(
    parameter int CLK_FREQ_HZ    = 50_000_000,
    parameter int BAUD_RATE      = 115200,
    parameter int BLOCK_SIZE     = 128,
    parameter int RAM_DEPTH      = 8192,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          prog_rx_i,
    output logic                          ram_wr_en_o,
    output logic [$clog2(RAM_DEPTH)-1:0]  ram_wr_addr_o,
    output logic [BLOCK_SIZE-1:0]         ram_wr_data_o,
    output logic [BLOCK_SIZE/8-1:0]       ram_wr_strb_o,
    output logic                          system_reset_o,
    output logic                          prog_mode_led_o
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int C_CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int C_HALF_BIT     = C_CLKS_PER_BIT / 2;
    localparam int C_NUMS_BYTE    = BLOCK_SIZE / 8;
    localparam int C_ADDR_W       = $clog2(RAM_DEPTH);
    localparam int C_POS_W        = (C_NUMS_BYTE > 1) ? $clog2(C_NUMS_BYTE) : 1;
    localparam int C_BAUD_W       = $clog2(C_CLKS_PER_BIT + 1);
    localparam int C_TIMER_W      = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [C_BAUD_W-1:0]  C_BIT_LAST   = C_BAUD_W'(C_CLKS_PER_BIT - 1);
    localparam logic [C_BAUD_W-1:0]  C_HALF_LAST  = C_BAUD_W'((C_HALF_BIT > 0) ? C_HALF_BIT - 1 : 0);
    localparam logic [C_TIMER_W-1:0] C_TIMER_LAST = C_TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [C_POS_W-1:0]   C_POS_LAST   = C_POS_W'(C_NUMS_BYTE - 1);
    localparam logic [C_ADDR_W-1:0]  C_ADDR_LAST  = C_ADDR_W'(RAM_DEPTH - 1);

    // ------------------------------------------------------------------------
    // State encodings
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MAGIC = 3'd1,
        S_LEN   = 3'd2,
        S_DATA  = 3'd3,
        S_FLUSH = 3'd4,
        S_DONE  = 3'd5
    } ld_state_t;

    // ------------------------------------------------------------------------
    // Key character lookup: index 0..8 of "TEKNOFEST"
    // ------------------------------------------------------------------------
    function automatic logic [7:0] magic_char(input logic [3:0] idx);
        logic [7:0] ch;
        case (idx)
            4'd0:    ch = 8'h54; // T
            4'd1:    ch = 8'h45; // E
            4'd2:    ch = 8'h4B; // K
            4'd3:    ch = 8'h4E; // N
            4'd4:    ch = 8'h4F; // O
            4'd5:    ch = 8'h46; // F
            4'd6:    ch = 8'h45; // E
            4'd7:    ch = 8'h53; // S
            4'd8:    ch = 8'h54; // T
            default: ch = 8'h00;
        endcase
        return ch;
    endfunction

    // ------------------------------------------------------------------------
    // Receiver signals
    // ------------------------------------------------------------------------
    logic                rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t           rx_state_q, rx_state_d;
    logic [C_BAUD_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]          rx_bit_q, rx_bit_d;
    logic [7:0]          rx_shift_q, rx_shift_d;
    logic                byte_valid_q, byte_valid_d;

    // ------------------------------------------------------------------------
    // Loader signals
    // ------------------------------------------------------------------------
    ld_state_t            state_q, state_d;
    logic [3:0]           match_q, match_d;
    logic [31:0]          len_q, len_d;
    logic [1:0]           len_cnt_q, len_cnt_d;
    logic [31:0]          rem_q, rem_d;
    logic [C_POS_W-1:0]   pos_q, pos_d;
    logic [BLOCK_SIZE-1:0] line_q, line_d;
    logic [C_ADDR_W-1:0]  line_addr_q, line_addr_d;
    logic [C_TIMER_W-1:0] timer_q, timer_d;
    logic                 wr_en_q, wr_en_d;
    logic [C_ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [BLOCK_SIZE-1:0] wr_data_q, wr_data_d;
    logic                 run_q, run_d;
    logic                 led_q, led_d;

    logic [BLOCK_SIZE-1:0] line_ins;     // line buffer with the current byte merged in
    logic [C_ADDR_W-1:0]   line_addr_nx; // next line address, wrapping at RAM_DEPTH
    logic [31:0]           len_full;     // byte count once the 4th length byte arrives
    logic                  active;       // timeout-supervised states
    logic                  timeout_hit;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= prog_rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Receiver next-state: start recheck at half bit, then sample at bit centres
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        byte_valid_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == C_HALF_LAST) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    // A line that has gone high again was only a glitch
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + C_BAUD_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == C_BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + C_BAUD_W'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == C_BIT_LAST) begin
                    rx_cnt_d     = '0;
                    rx_state_d   = RX_IDLE;
                    // Low stop bit is a framing error: byte silently dropped
                    byte_valid_d = rx_sync_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + C_BAUD_W'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Receiver state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            byte_valid_q <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            byte_valid_q <= byte_valid_d;
        end
    end

    // Helper values: merged line, wrapped address, assembled length, timeout
    always_comb begin
        line_ins = line_q;
        for (int i = 0; i < C_NUMS_BYTE; i++) begin
            if (pos_q == C_POS_W'(i)) begin
                line_ins[i*8 +: 8] = rx_shift_q;
            end
        end
        line_addr_nx = (line_addr_q == C_ADDR_LAST) ? '0 : line_addr_q + C_ADDR_W'(1);
        len_full     = {rx_shift_q, len_q[31:8]};
        active       = (state_q == S_LEN) || (state_q == S_DATA);
        timeout_hit  = active && !byte_valid_q && (timer_q == C_TIMER_LAST);
    end

    // Loader next-state: key match, length, payload packing, flush and release
    always_comb begin
        state_d     = state_q;
        match_d     = match_q;
        len_d       = len_q;
        len_cnt_d   = len_cnt_q;
        rem_d       = rem_q;
        pos_d       = pos_q;
        line_d      = line_q;
        line_addr_d = line_addr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        // CPU released one cycle after DONE; held one cycle after entering LEN
        run_d       = !((state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_FLUSH));
        led_d       = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_FLUSH);
        timer_d     = (active && !byte_valid_q) ? timer_q + C_TIMER_W'(1) : '0;

        case (state_q)
            S_IDLE, S_MAGIC: begin
                if (byte_valid_q) begin
                    if (rx_shift_q == magic_char(match_q)) begin
                        if (match_q == 4'd8) begin
                            state_d   = S_LEN;
                            match_d   = '0;
                            len_d     = '0;
                            len_cnt_d = '0;
                        end else begin
                            state_d = S_MAGIC;
                            match_d = match_q + 4'd1;
                        end
                    end else if (rx_shift_q == magic_char(4'd0)) begin
                        // A mismatching 'T' may itself start a new key
                        state_d = S_MAGIC;
                        match_d = 4'd1;
                    end else begin
                        state_d = S_IDLE;
                        match_d = '0;
                    end
                end
            end
            S_LEN: begin
                if (byte_valid_q) begin
                    len_d     = len_full;
                    len_cnt_d = len_cnt_q + 2'd1;
                    if (len_cnt_q == 2'd3) begin
                        if (len_full == 32'd0) begin
                            state_d = S_DONE;
                        end else begin
                            state_d     = S_DATA;
                            rem_d       = len_full;
                            pos_d       = '0;
                            line_d      = '0;
                            line_addr_d = '0;
                        end
                    end
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                end
            end
            S_DATA: begin
                if (byte_valid_q) begin
                    rem_d = rem_q - 32'd1;
                    if (pos_q == C_POS_LAST) begin
                        wr_en_d     = 1'b1;
                        wr_addr_d   = line_addr_q;
                        wr_data_d   = line_ins;
                        line_addr_d = line_addr_nx;
                        line_d      = '0;
                        pos_d       = '0;
                    end else begin
                        line_d = line_ins;
                        pos_d  = pos_q + C_POS_W'(1);
                    end
                    if (rem_q == 32'd1) begin
                        state_d = (pos_q == C_POS_LAST) ? S_DONE : S_FLUSH;
                    end
                end else if (timeout_hit) begin
                    state_d = (pos_q != '0) ? S_FLUSH : S_DONE;
                end
            end
            S_FLUSH: begin
                // Unfilled bytes are already zero since the buffer clears per line
                wr_en_d   = 1'b1;
                wr_addr_d = line_addr_q;
                wr_data_d = line_q;
                line_d    = '0;
                pos_d     = '0;
                state_d   = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Loader state and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            match_q     <= '0;
            len_q       <= '0;
            len_cnt_q   <= '0;
            rem_q       <= '0;
            pos_q       <= '0;
            line_q      <= '0;
            line_addr_q <= '0;
            timer_q     <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            run_q       <= 1'b1;
            led_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            match_q     <= match_d;
            len_q       <= len_d;
            len_cnt_q   <= len_cnt_d;
            rem_q       <= rem_d;
            pos_q       <= pos_d;
            line_q      <= line_d;
            line_addr_q <= line_addr_d;
            timer_q     <= timer_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            run_q       <= run_d;
            led_q       <= led_d;
        end
    end

    assign ram_wr_en_o     = wr_en_q;
    assign ram_wr_addr_o   = wr_addr_q;
    assign ram_wr_data_o   = wr_data_q;
    assign ram_wr_strb_o   = {C_NUMS_BYTE{wr_en_q}};
    assign system_reset_o  = run_q;
    assign prog_mode_led_o = led_q;

endmodule
`default_nettype wire
